// File: rtl/simplez_sequencer_pkg.sv
// Shared Simplez control definitions: opcodes, sequencer states,
// ALU selects and the microorder bundle.
package simplez_sequencer_pkg;

  localparam int OPW    = 3;
  localparam int ALUOPW = 2;

  typedef enum logic [2:0] {
    OP_ST   = 3'd0,
    OP_LD   = 3'd1,
    OP_ADD  = 3'd2,
    OP_BR   = 3'd3,
    OP_BZ   = 3'd4,
    OP_CLR  = 3'd5,
    OP_DEC  = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_INI  = 3'd0,
    S_I0   = 3'd1,
    S_I1   = 3'd2,
    S_O0   = 3'd3,
    S_O1   = 3'd4,
    S_WAIT = 3'd5,
    S_HLT  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_DEC  = 2'd2,
    ALU_CLR  = 2'd3
  } alu_e;

  typedef struct packed {
    logic lec;
    logic esc;
    logic era;
    logic eri;
    logic sri;
    logic scp;
    logic incp;
    logic ecp;
    logic eac;
    logic sac;
    alu_e alu_op;
    logic stop;
  } uorder_t;

endpackage

// File: rtl/simplez_uorder_dec.sv
// Microorder decoder: maps (state, opcode, AC-zero) onto the
// datapath control vector. Purely combinational.
module simplez_uorder_dec
  import simplez_sequencer_pkg::*;
(
  input  state_e  state_i,
  input  opcode_e co_i,
  input  logic    ac_zero_i,
  output uorder_t uo_o
);

  always_comb begin
    uo_o = '0;
    case (state_i)
      S_INI: begin
        uo_o.scp = 1'b1;
        uo_o.era = 1'b1;
      end
      S_I0: begin
        uo_o.lec  = 1'b1;
        uo_o.eri  = 1'b1;
        uo_o.incp = 1'b1;
      end
      S_I1: begin
        case (co_i)
          OP_ST, OP_LD, OP_ADD: begin
            uo_o.sri = 1'b1;
            uo_o.era = 1'b1;
          end
          OP_BR: begin
            uo_o.sri = 1'b1;
            uo_o.era = 1'b1;
            uo_o.ecp = 1'b1;
          end
          OP_BZ: begin
            // Taken: jump like BR; not taken: point RA back at CP.
            uo_o.era = 1'b1;
            uo_o.sri = ac_zero_i;
            uo_o.ecp = ac_zero_i;
            uo_o.scp = ~ac_zero_i;
          end
          OP_CLR: begin
            uo_o.eac    = 1'b1;
            uo_o.alu_op = ALU_CLR;
            uo_o.scp    = 1'b1;
            uo_o.era    = 1'b1;
          end
          OP_DEC: begin
            uo_o.eac    = 1'b1;
            uo_o.alu_op = ALU_DEC;
            uo_o.scp    = 1'b1;
            uo_o.era    = 1'b1;
          end
          OP_HALT: uo_o.stop = 1'b1;
          default: ;
        endcase
      end
      S_O0: begin
        case (co_i)
          OP_ST: begin
            uo_o.sac = 1'b1;
            uo_o.esc = 1'b1;
          end
          OP_LD: begin
            uo_o.lec    = 1'b1;
            uo_o.eac    = 1'b1;
            uo_o.alu_op = ALU_PASS;
          end
          OP_ADD: begin
            uo_o.lec    = 1'b1;
            uo_o.eac    = 1'b1;
            uo_o.alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_O1: begin
        uo_o.scp = 1'b1;
        uo_o.era = 1'b1;
      end
      S_HLT: uo_o.stop = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/simplez_sequencer.sv
// Simplez control unit: state register and next-state logic on the
// datapath (falling) edge, microorders from simplez_uorder_dec.
module simplez_sequencer
  import simplez_sequencer_pkg::*;
#(
  parameter int OPW    = 3,
  parameter int ALUOPW = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [OPW-1:0]    co,
  input  logic              ac_zero,
  input  logic              step_mode,
  input  logic              step,
  output logic              lec,
  output logic              esc,
  output logic              era,
  output logic              eri,
  output logic              sri,
  output logic              scp,
  output logic              incp,
  output logic              ecp,
  output logic              eac,
  output logic              sac,
  output logic [ALUOPW-1:0] alu_op,
  output logic              stop,
  output logic [2:0]        state_o
);

  state_e  state_q;
  state_e  state_d;
  state_e  dec_state;
  state_e  bnd_state;
  uorder_t uo;

  always_ff @(negedge clk) begin
    if (!rstn) state_q <= S_INI;
    else       state_q <= state_d;
  end

  assign bnd_state = step_mode ? S_WAIT : S_I0;

  always_comb begin
    state_d = S_INI;
    case (state_q)
      S_INI: state_d = bnd_state;
      S_I0:  state_d = S_I1;
      S_I1: begin
        case (opcode_e'(co))
          OP_ST, OP_LD, OP_ADD: state_d = S_O0;
          OP_HALT:              state_d = S_HLT;
          default:              state_d = bnd_state;
        endcase
      end
      S_O0:   state_d = S_O1;
      S_O1:   state_d = bnd_state;
      S_WAIT: state_d = (step || !step_mode) ? S_I0 : S_WAIT;
      S_HLT:  state_d = S_HLT;
      default: state_d = S_INI;
    endcase
  end

  // While rstn is low the outputs already show INI so no write can leak.
  assign dec_state = rstn ? state_q : S_INI;

  simplez_uorder_dec u_dec (
    .state_i   (dec_state),
    .co_i      (opcode_e'(co)),
    .ac_zero_i (ac_zero),
    .uo_o      (uo)
  );

  always_comb begin
    lec    = uo.lec;
    esc    = uo.esc;
    era    = uo.era;
    eri    = uo.eri;
    sri    = uo.sri;
    scp    = uo.scp;
    incp   = uo.incp;
    ecp    = uo.ecp;
    eac    = uo.eac;
    sac    = uo.sac;
    alu_op = ALUOPW'(uo.alu_op);
    stop   = uo.stop;
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_simplez_sequencer.sv
// Bench: small Simplez datapath around the sequencer, checked against
// an instruction-level ISA model plus directed literal expectations.
module tb_simplez_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  co;
  logic        ac_zero;
  logic        step_mode;
  logic        step;
  logic        lec, esc, era, eri, sri, scp;
  logic        incp, ecp, eac, sac, stop;
  logic [1:0]  alu_op;
  logic [2:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int prog_sel = 0;

  always #5 clk = ~clk;

  simplez_sequencer #(.OPW(3), .ALUOPW(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .co        (co),
    .ac_zero   (ac_zero),
    .step_mode (step_mode),
    .step      (step),
    .lec       (lec),
    .esc       (esc),
    .era       (era),
    .eri       (eri),
    .sri       (sri),
    .scp       (scp),
    .incp      (incp),
    .ecp       (ecp),
    .eac       (eac),
    .sac       (sac),
    .alu_op    (alu_op),
    .stop      (stop),
    .state_o   (state_o)
  );

  // Program images: 0 = directed main program, 1 = single-step program.
  function automatic logic [11:0] image(input int sel, input int a);
    logic [11:0] w;
    w = 12'h000;
    if (sel == 0) begin
      case (a)
        0:     w = 12'h2A5;
        1:     w = 12'h4A6;
        2:     w = 12'h100;
        3:     w = 12'h820;
        4:     w = 12'hA00;
        5:     w = 12'h820;
        'h20:  w = 12'hC00;
        'h21:  w = 12'hE00;
        'hA5:  w = 12'd3;
        'hA6:  w = 12'd4;
        default: w = 12'h000;
      endcase
    end else begin
      case (a)
        0: w = 12'hC00;
        1: w = 12'hC00;
        2: w = 12'hE00;
        default: w = 12'h000;
      endcase
    end
    return w;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Datapath driven by the microorders
  logic [11:0] mem [512];
  logic [8:0]  cp, ra;
  logic [11:0] ri, ac;
  logic [8:0]  bus_a;
  logic [11:0] bus_d, alu_res;

  assign co      = ri[11:9];
  assign ac_zero = (ac == 12'd0);

  always_comb begin
    bus_a = sri ? ri[8:0] : (scp ? cp : 9'd0);
    bus_d = lec ? mem[ra] : (sac ? ac : 12'd0);
    case (alu_op)
      2'd0: alu_res = bus_d;
      2'd1: alu_res = ac + bus_d;
      2'd2: alu_res = ac - 12'd1;
      default: alu_res = 12'd0;
    endcase
  end

  always @(negedge clk) begin
    if (!rstn) begin
      cp <= 9'd0;
      ra <= 9'd0;
      ri <= 12'd0;
      ac <= 12'd0;
      for (int i = 0; i < 512; i++) mem[i] <= image(prog_sel, i);
    end else begin
      if (era)  ra <= bus_a;
      if (eri)  ri <= bus_d;
      if (incp) cp <= cp + 9'd1;
      if (ecp)  cp <= bus_a;
      if (esc)  mem[ra] <= bus_d;
      if (eac)  ac <= alu_res;
    end
  end

  // ISA-level reference model and per-cycle compare process
  logic [11:0] mmem [512];
  logic [8:0]  mcp;
  logic [11:0] mac;
  logic        mhalt;
  logic        started;
  logic        st_pend;
  logic [8:0]  st_addr;
  int          cyc;
  int          exp_cyc;

  always @(posedge clk) begin
    logic [11:0] ir;
    logic [8:0]  cd;
    if (!rstn) begin
      mcp = 9'd0;
      mac = 12'd0;
      mhalt = 1'b0;
      started = 1'b0;
      st_pend = 1'b0;
      st_addr = 9'd0;
      cyc = 0;
      exp_cyc = 0;
      for (int i = 0; i < 512; i++) mmem[i] = image(prog_sel, i);
    end else begin
      check("invariant",
            {31'd0, (sac & lec) | (scp & sri) | (esc & lec) |
                    (ecp & (state_o != 3'd2))}, 32'd0);
      case (state_o)
        3'd1: begin
          if (started) check("instr_cycles", cyc, exp_cyc);
          if (st_pend) check("st_mem", {20'd0, mem[st_addr]},
                             {20'd0, mmem[st_addr]});
          check("fetch_ra", {23'd0, ra}, {23'd0, mcp});
          check("fetch_cp", {23'd0, cp}, {23'd0, mcp});
          check("arch_ac", {20'd0, ac}, {20'd0, mac});
          ir = mmem[mcp];
          cd = ir[8:0];
          mcp = mcp + 9'd1;
          exp_cyc = 2;
          st_pend = 1'b0;
          case (ir[11:9])
            3'd0: begin
              mmem[cd] = mac;
              st_pend = 1'b1;
              st_addr = cd;
              exp_cyc = 4;
            end
            3'd1: begin mac = mmem[cd]; exp_cyc = 4; end
            3'd2: begin mac = mac + mmem[cd]; exp_cyc = 4; end
            3'd3: mcp = cd;
            3'd4: if (mac == 12'd0) mcp = cd;
            3'd5: mac = 12'd0;
            3'd6: mac = mac - 12'd1;
            default: mhalt = 1'b1;
          endcase
          started = 1'b1;
          cyc = 1;
        end
        3'd2, 3'd3, 3'd4: cyc++;
        3'd6: begin
          if (cyc != 0) begin
            check("halt_cycles", cyc, exp_cyc);
            check("halt_model", {31'd0, mhalt}, 32'd1);
            cyc = 0;
          end
          check("hlt_stop", {31'd0, stop}, 32'd1);
        end
        default: ;
      endcase
    end
  end

  logic [12:0] uo_v;
  assign uo_v = {lec, esc, era, eri, sri, scp, incp, ecp, eac, sac,
                 alu_op, stop};

  initial begin
    int bad;
    logic [2:0] s;
    rstn = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    prog_sel = 0;

    repeat (2) @(negedge clk);
    @(posedge clk);
    check("reset_state", {29'd0, state_o}, 32'd0);
    check("reset_outs", {19'd0, uo_v}, {19'd0, 13'b0010010000000});
    #1 rstn = 1'b1;

    @(posedge clk);  // P0 I0 of LD
    check("release_i0", {29'd0, state_o}, 32'd1);
    repeat (2) @(posedge clk);  // P2 O0 LD
    check("ld_o0", {29'd0, lec, eac, alu_op}, 32'b1100);
    repeat (4) @(posedge clk);  // P6 O0 ADD
    check("add_o0", {29'd0, lec, eac, alu_op}, 32'b1101);
    repeat (2) @(posedge clk);  // P8 I0 ST
    check("ld_add_ac", {20'd0, ac}, 32'd7);
    @(posedge clk);  // P9 I1 ST
    check("st_i1_noesc", {30'd0, esc, sac}, 32'd0);
    @(posedge clk);  // P10 O0 ST
    check("st_o0", {21'd0, esc, sac, ra}, {21'd0, 2'b11, 9'h100});
    @(posedge clk);  // P11 O1 ST
    check("st_o1", {28'd0, esc, scp, era, sri}, 32'b0110);
    check("st_mem_lit", {20'd0, mem[9'h100]}, 32'd7);
    @(posedge clk);  // P12 I0 BZ
    check("o1_ra_cp", {23'd0, ra}, 32'd3);
    @(posedge clk);  // P13 I1 BZ not taken
    check("bz_nt_ecp", {31'd0, ecp}, 32'd0);
    @(posedge clk);  // P14 I0 CLR
    check("bz_nt_fetch", {23'd0, ra}, 32'd4);
    repeat (3) @(posedge clk);  // P17 I1 BZ taken
    check("bz_t_ecp", {31'd0, ecp}, 32'd1);
    @(posedge clk);  // P18 I0 at 0x020
    check("bz_t_fetch", {23'd0, ra}, 32'h020);
    repeat (3) @(posedge clk);  // P21 I1 HALT
    check("halt_i1", {28'd0, stop, state_o}, {28'd0, 1'b1, 3'd2});
    check("halt_i1_quiet", {19'd0, uo_v}, 32'd1);
    @(posedge clk);  // P22 HLT
    check("halt_state", {29'd0, state_o}, 32'd6);
    check("halt_ac", {20'd0, ac}, 32'hFFF);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (state_o != 3'd6 || uo_v != 13'd1) bad++;
      #1 step = (i % 10 == 3);
      step_mode = (i >= 50);
    end
    check("hlt_hold", bad, 0);

    #1 prog_sel = 1;
    rstn = 1'b0;
    step = 1'b0;
    step_mode = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    check("rst_recover", {29'd0, state_o}, 32'd0);
    #1 rstn = 1'b1;
    @(posedge clk);
    check("step_wait", {29'd0, state_o}, 32'd5);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      if (state_o != 3'd5 || uo_v != 13'd0) bad++;
    end
    check("wait_hold", bad, 0);

    for (int p = 0; p < 2; p++) begin
      #1 step = 1'b1;
      @(posedge clk);
      s = state_o;
      #1 step = 1'b0;
      check("step_i0", {29'd0, s}, 32'd1);
      repeat (2) @(posedge clk);
      check("dec_wait", {29'd0, state_o}, 32'd5);
      check("dec_ac", {20'd0, ac}, (p == 0) ? 32'hFFF : 32'hFFE);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        if (state_o != 3'd5) bad++;
      end
      check("one_per_pulse", bad, 0);
    end

    #1 step_mode = 1'b0;
    bad = 1;
    for (int i = 0; i < 20 && bad != 0; i++) begin
      @(posedge clk);
      if (state_o == 3'd6) bad = 0;
    end
    check("resume_to_halt", bad, 0);
    check("final_ac", {20'd0, ac}, 32'hFFE);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
